// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage register placed on every
// IF/ID/EX/MEM/WB boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam int OCC_W = 2;

  function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
    logic [OCC_W-1:0] n;
    n = '0;
    case (s)
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Elastic valid/ready stage register with optional two-entry skid buffer,
// synchronous squash and a saturating back-pressure counter.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_t     state_reg;
  stage_state_t     state_next;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] main_next;
  logic [WIDTH-1:0] skid_data;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign occupancy = occ_of(state_reg);
  assign stall_cnt = stall_cnt_reg;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Shared FSM; TWO is only reachable when the skid register exists because
  // the single-register variant never accepts while full and stalled.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          state_next = ONE;
          main_next  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (out_fire) begin
          state_next = EMPTY;
        end else if (in_fire && (SKID_EN != 0)) begin
          state_next = TWO;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_next = ONE;
          main_next  = skid_data;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next = EMPTY;
      main_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic [WIDTH-1:0] skid_reg;
      logic             in_ready_reg;

      // in_ready is a flop so upstream never sees a path from out_ready.
      always_ff @(posedge clk) begin
        if (reset) begin
          skid_reg     <= '0;
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != TWO);
          if (flush) begin
            skid_reg <= '0;
          end else if ((state_reg == ONE) && in_fire && !out_fire) begin
            skid_reg <= in_data;
          end
        end
      end

      assign in_ready  = in_ready_reg;
      assign skid_data = skid_reg;
    end else begin : g_noskid
      assign in_ready  = !out_valid | out_ready;
      assign skid_data = '0;
    end
  endgenerate

endmodule
